// File: rtl/sctb_scoreboard.sv
// rtl/sctb_scoreboard.sv - in-order expected/actual scoreboard with saturating counters (optional SCB_MASK_EN)
module sctb_scoreboard #(
    parameter int W       = 8,
    parameter int DEPTH   = 16,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exp_valid,
    input  logic [W-1:0]               exp_data,
`ifdef SCB_MASK_EN
    input  logic [W-1:0]               exp_mask,
`endif
    output logic                       exp_ready,
    input  logic                       act_valid,
    input  logic [W-1:0]               act_data,
    output logic                       match_pulse,
    output logic                       mismatch_pulse,
    output logic                       err_pulse,
    output logic [W-1:0]               last_exp,
    output logic [W-1:0]               last_act,
    output logic [CW-1:0]              match_count,
    output logic [CW-1:0]              err_count,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       pass
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 2) + 1;
    localparam logic [CW-1:0] CMAX = '1;

    logic [W-1:0]  data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [PW-1:0] count_next;
    logic [TW-1:0] wait_cnt;

    logic          full;
    logic          empty;
    logic [W-1:0]  head_data;
    logic [W-1:0]  head_mask;
    logic          push_ok;
    logic          overflow;
    logic          cmp;
    logic          unexpected;
    logic          is_match;
    logic          is_mismatch;
    logic          timeout_hit;
    logic          pop;
    logic [1:0]    n_err;
    logic [CW+1:0] err_sum;

`ifdef SCB_MASK_EN
    logic [W-1:0]  mask_mem [DEPTH];

    // mask travels with its expected value so each entry compares on its own bits
    always_ff @(posedge clk) begin
        if (push_ok) mask_mem[wr_ptr] <= exp_mask;
    end

    assign head_mask = mask_mem[rd_ptr];
`else
    assign head_mask = '1;
`endif

    // expected-value storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) data_mem[wr_ptr] <= exp_data;
    end

    assign head_data = data_mem[rd_ptr];

    // classify this cycle's events; full is the registered state so a same-cycle pop never frees a slot
    always_comb begin
        full        = (count == PW'(DEPTH));
        empty       = (count == '0);
        push_ok     = exp_valid && !full;
        overflow    = exp_valid && full;
        cmp         = act_valid && !empty;
        unexpected  = act_valid && empty;
        is_mismatch = cmp && (|((head_data ^ act_data) & head_mask));
        is_match    = cmp && !is_mismatch;
        // a compare in the same cycle always wins over the timeout
        timeout_hit = (TIMEOUT != 0) && !empty && !act_valid && (wait_cnt == TW'(TIMEOUT - 1));
        pop         = cmp || timeout_hit;
        n_err       = 2'({1'b0, overflow}) + 2'({1'b0, is_mismatch})
                    + 2'({1'b0, unexpected}) + 2'({1'b0, timeout_hit});
        err_sum     = {2'b00, err_count} + (CW+2)'(n_err);
        count_next  = count;
        if (push_ok && !pop)      count_next = count + PW'(1);
        else if (!push_ok && pop) count_next = count - PW'(1);
    end

    // queue pointers, wait counter, registered pulses and saturating counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            wait_cnt       <= '0;
            exp_ready      <= 1'b1;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            err_pulse      <= 1'b0;
            last_exp       <= '0;
            last_act       <= '0;
            match_count    <= '0;
            err_count      <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            exp_ready <= (count_next != PW'(DEPTH));

            if ((TIMEOUT == 0) || empty || pop) wait_cnt <= '0;
            else                                wait_cnt <= wait_cnt + TW'(1);

            match_pulse    <= is_match;
            mismatch_pulse <= is_mismatch;
            err_pulse      <= (n_err != 2'd0);

            if (is_mismatch) begin
                last_exp <= head_data;
                last_act <= act_data;
            end

            if (is_match && (match_count != CMAX)) match_count <= match_count + CW'(1);

            if (err_sum > {2'b00, CMAX}) err_count <= CMAX;
            else                         err_count <= err_sum[CW-1:0];
        end
    end

    assign pending = count;
    assign pass    = (count == '0) && (err_count == '0);

endmodule

// File: doc/sctb_scoreboard.md
Name: sctb_scoreboard

Overview:
- Parametrised in-order scoreboard for self-checking benches.
- Successor to per-bench hand-written check/report tasks: generalised in data width, queue depth and error classes.
- Sits beside the DUV. The stimulus side pushes expected values; the monitor side presents actual DUV outputs.
- Compares in order and keeps saturating match/error counts plus a pass flag, which the bench reads at end of test.

Parameters:
- W, 8, data width of expected/actual values.
- DEPTH, 16, expected-value queue depth, power of 2, minimum 2.
- CW, 16, width of the match and error counters.
- TIMEOUT, 1000, max cycles the queue head may wait for an actual value; 0 disables the timeout check.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- exp_valid  input  1  push expected value this cycle.
- exp_data  input  W  expected value.
- exp_ready  output  1  queue not full (registered).
- act_valid  input  1  actual DUV value present this cycle.
- act_data  input  W  actual value.
- match_pulse  output  1  one-cycle pulse: last compare matched.
- mismatch_pulse  output  1  one-cycle pulse: last compare mismatched.
- err_pulse  output  1  one-cycle pulse: any error class this cycle.
- last_exp  output  W  expected value of most recent mismatch.
- last_act  output  W  actual value of most recent mismatch.
- match_count  output  CW  saturating count of matches.
- err_count  output  CW  saturating count of all errors.
- pending  output  $clog2(DEPTH)+1  entries in the queue.
- pass  output  1  pending==0 && err_count==0.

Behaviour:
- Reset, asynchronous: queue empty, pending=0, exp_ready=1, all pulses 0, counts 0, last_exp/last_act 0, timeout counter 0, pass=1.
- Push: on exp_valid && !full, exp_data is written at the tail; pending increments.
- Overflow: on exp_valid && full, the value is dropped, err_count increments and err_pulse is set.
  - Full is the registered state. A push into a full queue is rejected even if a pop occurs in the same cycle.
- Compare: on act_valid && pending!=0, act_data is compared with the head and the head is popped.
  - Equal: match_pulse=1 next cycle; match_count increments.
  - Unequal: mismatch_pulse=1 and err_pulse=1 next cycle; err_count increments; last_exp/last_act capture head/act_data.
- Unexpected: on act_valid && pending==0, err_count increments and err_pulse is set. There is no bypass.
  - A push in the same cycle is still queued but is not compared against this actual value.
- Simultaneous push and pop with pending in 1..DEPTH-1: both occur; pending is unchanged.
- Pulses: registered and one cycle wide; they appear in the cycle after the triggering edge. Counts update at that same edge.
- Timeout:
  - The wait counter increments each cycle with pending!=0 and no pop.
  - It clears on a pop or when the queue is empty.
  - On reaching TIMEOUT, the head is discarded, err_count increments, err_pulse is set and the counter clears.
  - If act_valid arrives in the same cycle as the timeout, the compare wins and no timeout is counted.
- Counters saturate at 2^CW-1; they do not wrap.
- Multiple error classes in one cycle (overflow + mismatch): err_count adds the number of errors, saturating.
- Reset mid-operation clears the queue and all counts immediately.

Optional Feature:
- Macro: SCB_MASK_EN.
- Defined:
  - Adds input exp_mask [W] (1 = compare this bit), stored per entry with exp_data.
  - The compare is (head ^ act) & mask.
  - last_exp reports the unmasked stored value.
- Undefined: there is no exp_mask port; all W bits are compared.

Test Plan:
- Reset, push 0x11, 0x22, 0x33, then actuals 0x11, 0x22, 0x33 -> 3 match_pulses, match_count=3, err_count=0, pending=0, pass=1.
- Push 0xA5, actual 0x5A -> mismatch_pulse and err_pulse one cycle, last_exp=0xA5, last_act=0x5A, err_count=1, pass=0.
- Push 17 values with DEPTH=16 and no actuals -> exp_ready=0 after 16 pushes, 17th dropped, err_count=1, pending=16.
- act_valid with empty queue while exp_valid pushes 0x07 in the same cycle -> err_count=1, pending=1, next actual 0x07 matches.
- TIMEOUT=5: push 0x01 and withhold actuals -> err_pulse 5 cycles after the push, pending=0, err_count=1.
- SCB_MASK_EN: push 0xF0 with mask 0xF0, actual 0xFF -> match_pulse; with mask 0xFF -> mismatch.
